// File: rtl/axi_ni_outstanding_tracker.sv
// Per-ID outstanding AW/AR transaction tracker for the initiator NI.
// Keeps same-ID transactions on a single NoC target until all earlier ones retire.
module axi_ni_outstanding_tracker #(
   parameter int MAX_SUPPORTED_IDS = 16,
   parameter int IDWD              = 4,
   parameter int CNTWD             = 3,
   parameter int TARGET_WD         = 14
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         aw_fire,
   input  logic [IDWD-1:0]              awid,
   input  logic [TARGET_WD-1:0]         aw_target,
   input  logic                         ar_fire,
   input  logic [IDWD-1:0]              arid,
   input  logic [TARGET_WD-1:0]         ar_target,
   input  logic [MAX_SUPPORTED_IDS-1:0] decr_outs_wr_cntr,
   input  logic [MAX_SUPPORTED_IDS-1:0] decr_outs_rd_cntr,
   output logic                         aw_allow,
   output logic                         ar_allow,
   output logic [MAX_SUPPORTED_IDS-1:0] response_awaited,
   output logic [MAX_SUPPORTED_IDS-1:0] read_awaited,
   output logic                         wait_read_response,
   output logic                         idle,
   output logic                         err_overflow,
   output logic                         err_underflow
);

   localparam logic [CNTWD-1:0] CNT_MAX = '1;

   logic [CNTWD-1:0]             wcnt     [MAX_SUPPORTED_IDS];
   logic [CNTWD-1:0]             rcnt     [MAX_SUPPORTED_IDS];
   logic [TARGET_WD-1:0]         wtgt     [MAX_SUPPORTED_IDS];
   logic [TARGET_WD-1:0]         rtgt     [MAX_SUPPORTED_IDS];
   logic [CNTWD-1:0]             wcnt_nxt [MAX_SUPPORTED_IDS];
   logic [CNTWD-1:0]             rcnt_nxt [MAX_SUPPORTED_IDS];
   logic [TARGET_WD-1:0]         wtgt_nxt [MAX_SUPPORTED_IDS];
   logic [TARGET_WD-1:0]         rtgt_nxt [MAX_SUPPORTED_IDS];
   logic [MAX_SUPPORTED_IDS-1:0] w_inc, r_inc, w_ovf, w_unf, r_ovf, r_unf;

   // Returns {overflow, underflow, next_count}; a colliding inc/dec leaves the count alone.
   function automatic logic [CNTWD+1:0] cnt_step(input logic [CNTWD-1:0] cnt,
                                                  input logic inc, input logic dec);
      logic [CNTWD+1:0] res;
      res = {2'b00, cnt};
      if (inc && !dec) begin
         if (cnt == CNT_MAX) res[CNTWD+1] = 1'b1;
         else                res[CNTWD-1:0] = cnt + 1'b1;
      end else if (dec && !inc) begin
         if (cnt == '0) res[CNTWD] = 1'b1;
         else           res[CNTWD-1:0] = cnt - 1'b1;
      end
      return res;
   endfunction

   // A target is only (re)captured when the new request becomes the sole outstanding one.
   function automatic logic tgt_capture(input logic [CNTWD-1:0] cnt,
                                        input logic inc, input logic dec);
      return inc && ((cnt == '0) || (dec && (cnt == CNTWD'(1))));
   endfunction

   always_comb begin
      w_inc = '0;
      r_inc = '0;
      for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
         w_inc[i] = aw_fire && (awid == IDWD'(i));
         r_inc[i] = ar_fire && (arid == IDWD'(i));
         {w_ovf[i], w_unf[i], wcnt_nxt[i]} = cnt_step(wcnt[i], w_inc[i], decr_outs_wr_cntr[i]);
         {r_ovf[i], r_unf[i], rcnt_nxt[i]} = cnt_step(rcnt[i], r_inc[i], decr_outs_rd_cntr[i]);
         wtgt_nxt[i] = tgt_capture(wcnt[i], w_inc[i], decr_outs_wr_cntr[i]) ? aw_target : wtgt[i];
         rtgt_nxt[i] = tgt_capture(rcnt[i], r_inc[i], decr_outs_rd_cntr[i]) ? ar_target : rtgt[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
            wcnt[i] <= '0;
            rcnt[i] <= '0;
            wtgt[i] <= '0;
            rtgt[i] <= '0;
         end
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
            wcnt[i] <= '0;
            rcnt[i] <= '0;
            wtgt[i] <= '0;
            rtgt[i] <= '0;
         end
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
            wcnt[i] <= wcnt_nxt[i];
            rcnt[i] <= rcnt_nxt[i];
            wtgt[i] <= wtgt_nxt[i];
            rtgt[i] <= rtgt_nxt[i];
         end
         err_overflow  <= err_overflow  | (|w_ovf) | (|r_ovf);
         err_underflow <= err_underflow | (|w_unf) | (|r_unf);
      end
   end

   always_comb begin
      response_awaited = '0;
      read_awaited     = '0;
      for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
         response_awaited[i] = (wcnt[i] != '0);
         read_awaited[i]     = (rcnt[i] != '0);
      end
   end

   assign wait_read_response = |read_awaited;
   assign idle               = ~(|response_awaited) & ~(|read_awaited);

   // Gating looks only at registered state; a retire in the same cycle does not open the gate.
   assign aw_allow = (wcnt[awid] != CNT_MAX) && ((wcnt[awid] == '0) || (wtgt[awid] == aw_target));
   assign ar_allow = (rcnt[arid] != CNT_MAX) && ((rcnt[arid] == '0) || (rtgt[arid] == ar_target));

endmodule
